// File: rtl/unified_mem_arbiter.sv
// Unified instruction/data byte memory shared by a fetch port and a data port, with data-priority
// arbitration bounded by a starvation limit. Define MISALIGN_TRAP_EN to trap misaligned LH/LW/SH/SW.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [2:0]        d_funct3,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              d_misalign
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int STW = $clog2(MAX_STARVE + 1);
  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);
  localparam logic [STW-1:0] STARVE_MAX = STW'(MAX_STARVE);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [STW-1:0]    starve_q, starve_d;
  logic              gnt_data_q;
  logic [31:0]       res_q;
  logic              if_ready_q, d_ready_q;
  logic [31:0]       if_rdata_q, d_rdata_q;
  logic              arb_en_s, grant_s, gnt_data_s;
  logic [ADDR_W-1:0] addr_s;
  logic [ADDR_W-3:0] wa_hi_s;
  logic              is_byte_s, is_half_s, mis_s, do_write_s;
  logic [31:0]       word_s, load_s, res_s, wdat_s;
  logic [7:0]        byte_s;
  logic [15:0]       half_s;
  logic [3:0]        wen_s;
  logic              fire_s, fire_data_s;
  logic [31:0]       fire_res_s;
  logic [7:0]        mem [DEPTH];
`ifdef MISALIGN_TRAP_EN
  logic              mis_q, d_misalign_q, fire_mis_s;
`endif

  // Next-state, latency countdown and starvation bookkeeping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    arb_en_s = 1'b0;
    case (state_q)
      IDLE:    arb_en_s = 1'b1;
      ACCESS: begin
        if (cnt_q == 2'd0) arb_en_s = 1'b1;
        else               cnt_d = cnt_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
    gnt_data_s = d_req && !(if_req && (starve_q == STARVE_MAX));
    grant_s    = arb_en_s && (d_req || if_req);
    if (grant_s) begin
      state_d = ACCESS;
      cnt_d   = LAT_M1;
    end else if (arb_en_s) begin
      state_d = IDLE;
    end else begin
      state_d = state_q;
    end
    if (!if_req)                   starve_d = {STW{1'b0}};
    else if (grant_s && gnt_data_s) starve_d = starve_q + 1'b1;
    else if (grant_s)              starve_d = {STW{1'b0}};
    else                           starve_d = starve_q;
  end

  // Access datapath for the port being granted this cycle.
  always_comb begin
    addr_s    = gnt_data_s ? d_addr : if_addr;
    is_byte_s = gnt_data_s && (d_funct3[1:0] == 2'b00);
    is_half_s = gnt_data_s && (d_funct3[1:0] == 2'b01);
    wa_hi_s   = addr_s[ADDR_W-1:2];
    word_s    = {mem[{wa_hi_s, 2'd3}], mem[{wa_hi_s, 2'd2}],
                 mem[{wa_hi_s, 2'd1}], mem[{wa_hi_s, 2'd0}]};
    case (addr_s[1:0])
      2'd0:    byte_s = word_s[7:0];
      2'd1:    byte_s = word_s[15:8];
      2'd2:    byte_s = word_s[23:16];
      2'd3:    byte_s = word_s[31:24];
      default: byte_s = 8'd0;
    endcase
    half_s = addr_s[1] ? word_s[31:16] : word_s[15:0];
    if (is_byte_s)      load_s = d_funct3[2] ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
    else if (is_half_s) load_s = d_funct3[2] ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
    else                load_s = word_s;
`ifdef MISALIGN_TRAP_EN
    mis_s = (is_half_s && addr_s[0]) ||
            (gnt_data_s && !is_byte_s && !is_half_s && (addr_s[1:0] != 2'b00));
`else
    mis_s = 1'b0;
`endif
    if (!gnt_data_s)        res_s = word_s;
    else if (d_we || mis_s) res_s = 32'd0;
    else                    res_s = load_s;
    if (is_byte_s)      wen_s = 4'b0001 << addr_s[1:0];
    else if (is_half_s) wen_s = addr_s[1] ? 4'b1100 : 4'b0011;
    else                wen_s = 4'b1111;
    if (is_byte_s)      wdat_s = {4{d_wdata[7:0]}};
    else if (is_half_s) wdat_s = {2{d_wdata[15:0]}};
    else                wdat_s = d_wdata;
    do_write_s = grant_s && gnt_data_s && d_we && !mis_s;
  end

  // Completion: at grant for single-cycle latency, otherwise one countdown step before cnt hits 0.
  always_comb begin
    if (MEM_LAT == 1) begin
      fire_s      = grant_s;
      fire_data_s = gnt_data_s;
      fire_res_s  = res_s;
`ifdef MISALIGN_TRAP_EN
      fire_mis_s  = mis_s;
`endif
    end else begin
      fire_s      = (state_q == ACCESS) && (cnt_q == 2'd1);
      fire_data_s = gnt_data_q;
      fire_res_s  = res_q;
`ifdef MISALIGN_TRAP_EN
      fire_mis_s  = mis_q;
`endif
    end
  end

  // Byte-lane store commit at the grant edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (reset && do_write_s) begin
      if (wen_s[0]) mem[{wa_hi_s, 2'd0}] <= wdat_s[7:0];
      if (wen_s[1]) mem[{wa_hi_s, 2'd1}] <= wdat_s[15:8];
      if (wen_s[2]) mem[{wa_hi_s, 2'd2}] <= wdat_s[23:16];
      if (wen_s[3]) mem[{wa_hi_s, 2'd3}] <= wdat_s[31:24];
    end
  end

  // Control state, latched access result and registered port outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      starve_q     <= {STW{1'b0}};
      gnt_data_q   <= 1'b0;
      res_q        <= 32'd0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      if_rdata_q   <= 32'd0;
      d_rdata_q    <= 32'd0;
`ifdef MISALIGN_TRAP_EN
      mis_q        <= 1'b0;
      d_misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      if (grant_s) begin
        gnt_data_q <= gnt_data_s;
        res_q      <= res_s;
`ifdef MISALIGN_TRAP_EN
        mis_q      <= mis_s;
`endif
      end
      if_ready_q <= fire_s && !fire_data_s;
      d_ready_q  <= fire_s && fire_data_s;
      if (fire_s && !fire_data_s) if_rdata_q <= fire_res_s;
      if (fire_s && fire_data_s)  d_rdata_q  <= fire_res_s;
`ifdef MISALIGN_TRAP_EN
      d_misalign_q <= fire_s && fire_data_s && fire_mis_s;
`endif
    end
  end

  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);
  assign stall_if  = if_req && !if_ready_q;
  assign stall_mem = d_req && !d_ready_q;
`ifdef MISALIGN_TRAP_EN
  assign d_misalign = d_misalign_q;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed-vector bench for unified_mem_arbiter: one instance at MEM_LAT=1 (index 0), one at MEM_LAT=3 (index 1).
module tb_unified_mem_arbiter;
  localparam int AW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset [2];
  logic        if_req [2];
  logic [AW-1:0] if_addr [2];
  logic        if_ready [2];
  logic [31:0] if_rdata [2];
  logic        d_req [2];
  logic        d_we [2];
  logic [AW-1:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic [2:0]  d_funct3 [2];
  logic        d_ready [2];
  logic [31:0] d_rdata [2];
  logic        stall_if [2];
  logic        stall_mem [2];
  logic        busy [2];
`ifdef MISALIGN_TRAP_EN
  logic        d_misalign [2];
`endif

  int vectors = 0;
  int miscompares = 0;
  logic last_mis = 1'b0;
  logic last_stall = 1'b0;

  unified_mem_arbiter #(.ADDR_W(AW), .MEM_LAT(1), .MAX_STARVE(4)) u_lat1 (
    .clk(clk), .reset(reset[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ready(if_ready[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_funct3(d_funct3[0]), .d_ready(d_ready[0]), .d_rdata(d_rdata[0]),
    .stall_if(stall_if[0]), .stall_mem(stall_mem[0]), .busy(busy[0])
`ifdef MISALIGN_TRAP_EN
    , .d_misalign(d_misalign[0])
`endif
  );

  unified_mem_arbiter #(.ADDR_W(AW), .MEM_LAT(3), .MAX_STARVE(4)) u_lat3 (
    .clk(clk), .reset(reset[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ready(if_ready[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_funct3(d_funct3[1]), .d_ready(d_ready[1]), .d_rdata(d_rdata[1]),
    .stall_if(stall_if[1]), .stall_mem(stall_mem[1]), .busy(busy[1])
`ifdef MISALIGN_TRAP_EN
    , .d_misalign(d_misalign[1])
`endif
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Issue one data access and hold it until d_ready; lat counts clock edges to ready (20 = timeout).
  task automatic data_op(input int k, input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output int lat);
    @(negedge clk);
    d_we[k] = we; d_funct3[k] = f3; d_addr[k] = a; d_wdata[k] = wd; d_req[k] = 1'b1;
    #1 last_stall = stall_mem[k];
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!d_ready[k] && lat < 20);
    rd = d_rdata[k];
`ifdef MISALIGN_TRAP_EN
    last_mis = d_misalign[k];
`endif
    d_req[k] = 1'b0;
  endtask

  task automatic fetch_op(input int k, input logic [AW-1:0] a, output logic [31:0] rd, output int lat);
    @(negedge clk);
    if_addr[k] = a; if_req[k] = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!if_ready[k] && lat < 20);
    rd = if_rdata[k];
    if_req[k] = 1'b0;
  endtask

  logic [2:0]  t2_f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
  logic [8:0]  t2_adr [4] = '{9'h013, 9'h013, 9'h012, 9'h012};
  logic [31:0] t2_exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD};

  initial begin
    logic [31:0] rd;
    int lat, lat_exp, n, both, pulses;
    logic [9:0] seq;

    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b0; if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_addr[k] = '0; d_wdata[k] = 32'd0; d_funct3[k] = 3'b010;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_vec("rst_busy", 32'(busy[k]), 32'd0);
      check_vec("rst_ready", {30'd0, d_ready[k], if_ready[k]}, 32'd0);
      check_vec("rst_rdata", d_rdata[k] | if_rdata[k], 32'd0);
    end
    reset[0] = 1'b1; reset[1] = 1'b1;

    // SW/LW round trip and latency at both MEM_LAT settings.
    for (int k = 0; k < 2; k++) begin
      lat_exp = (k == 0) ? 1 : 3;
      data_op(k, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, rd, lat);
      check_vec("sw_lat", 32'(lat), 32'(lat_exp));
      check_vec("stall_mem", 32'(last_stall), 32'd1);
      data_op(k, 1'b0, 3'b010, 9'h010, 32'd0, rd, lat);
      check_vec("lw_lat", 32'(lat), 32'(lat_exp));
      check_vec("lw_data", rd, 32'hDEADBEEF);
    end

    for (int i = 0; i < 4; i++) begin
      data_op(0, 1'b0, t2_f3[i], t2_adr[i], 32'd0, rd, lat);
      check_vec("sub_load", rd, t2_exp[i]);
    end

    data_op(0, 1'b1, 3'b000, 9'h011, 32'h00000055, rd, lat);
    data_op(0, 1'b0, 3'b010, 9'h010, 32'd0, rd, lat);
    check_vec("sb_merge", rd, 32'hDEAD55EF);
    data_op(0, 1'b1, 3'b001, 9'h012, 32'h00001234, rd, lat);
    data_op(0, 1'b0, 3'b010, 9'h010, 32'd0, rd, lat);
    check_vec("sh_merge", rd, 32'h123455EF);

`ifdef MISALIGN_TRAP_EN
    data_op(0, 1'b0, 3'b010, 9'h012, 32'd0, rd, lat);
    check_vec("mis_lw_data", rd, 32'd0);
    check_vec("mis_lw_flag", 32'(last_mis), 32'd1);
    check_vec("mis_lw_lat", 32'(lat), 32'd1);
    data_op(0, 1'b1, 3'b010, 9'h012, 32'hCAFEF00D, rd, lat);
    check_vec("mis_sw_flag", 32'(last_mis), 32'd1);
    data_op(0, 1'b0, 3'b010, 9'h010, 32'd0, rd, lat);
    check_vec("mis_sw_mem", rd, 32'h123455EF);
    check_vec("aligned_flag", 32'(last_mis), 32'd0);
`else
    data_op(0, 1'b0, 3'b010, 9'h012, 32'd0, rd, lat);
    check_vec("mask_lw", rd, 32'h123455EF);
`endif
    fetch_op(0, 9'h013, rd, lat);
    check_vec("fetch_data", rd, 32'h123455EF);
    check_vec("fetch_lat", 32'(lat), 32'd1);

    // Both requesters held: data priority with a fetch forced after four data grants.
    @(negedge clk);
    d_we[0] = 1'b0; d_funct3[0] = 3'b010; d_addr[0] = 9'h010; if_addr[0] = 9'h010;
    d_req[0] = 1'b1; if_req[0] = 1'b1;
    n = 0; both = 0; seq = 10'd0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      @(posedge clk); #1;
      if (d_ready[0] && if_ready[0]) both++;
      if (d_ready[0] || if_ready[0]) begin
        seq[n] = if_ready[0];
        n++;
      end
    end
    d_req[0] = 1'b0; if_req[0] = 1'b0;
    check_vec("arb_order", 32'(seq), 32'h00000210);
    check_vec("arb_count", 32'(n), 32'd10);
    check_vec("arb_both", 32'(both), 32'd0);
    check_vec("arb_ifdata", if_rdata[0], 32'h123455EF);
    repeat (3) @(negedge clk);
    check_vec("arb_idle", 32'(busy[0]), 32'd0);

    // Reset in the middle of a MEM_LAT=3 store.
    @(negedge clk);
    d_we[1] = 1'b1; d_funct3[1] = 3'b010; d_addr[1] = 9'h020; d_wdata[1] = 32'h11223344; d_req[1] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check_vec("pre_rst_busy", 32'(busy[1]), 32'd1);
    reset[1] = 1'b0;
    #1;
    check_vec("mid_rst_busy", 32'(busy[1]), 32'd0);
    check_vec("mid_rst_ready", {30'd0, d_ready[1], if_ready[1]}, 32'd0);
    check_vec("mid_rst_rdata", d_rdata[1] | if_rdata[1], 32'd0);
    d_req[1] = 1'b0;
    pulses = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (d_ready[1] || if_ready[1]) pulses++;
    end
    @(negedge clk);
    reset[1] = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (d_ready[1] || if_ready[1]) pulses++;
    end
    check_vec("rst_no_pulse", 32'(pulses), 32'd0);
    check_vec("rst_rel_busy", 32'(busy[1]), 32'd0);
    data_op(1, 1'b0, 3'b010, 9'h020, 32'd0, rd, lat);
    check_vec("rst_store_kept", rd, 32'h11223344);
    fetch_op(1, 9'h010, rd, lat);
    check_vec("rst_fetch_data", rd, 32'hDEADBEEF);
    check_vec("rst_fetch_lat", 32'(lat), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
